sort_sum_detect: RTL and testbench

//  Downstream of the top-16 sorter (sort2in1). Segments its DataEn stream into frames of

---
 rtl/sort_pkg.sv | 24 ++
 rtl/sort_hyst_fsm.sv | 48 ++++
 rtl/sort_sum_detect.sv | 138 +++++++++++++
 tb/tb_sort_sum_detect.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// sort_pkg: shared constants, frame FSM encoding and width helper for the sort-sum
// detection slice.
package sort_pkg;

    typedef enum logic [1:0] {
        ST_COUNT  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPORT = 2'd2
    } frame_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned TOPK      = 16;
    localparam int unsigned SUM_SHIFT = clog2(TOPK);
    localparam int unsigned RND       = 8;

endpackage

// File: rtl/sort_hyst_fsm.sv
// sort_hyst_fsm: hysteretic Detect flag; HOLD consecutive qualifying frames flip the
// flag, any non-qualifying frame restarts the run.
module sort_hyst_fsm
    import sort_pkg::*;
#(
    parameter int unsigned W    = 12,
    parameter int unsigned HOLD = 2
) (
    input  logic         clk,
    input  logic         rst_x,
    input  logic         AvgVld,
    input  logic [W-1:0] AvgOut,
    input  logic [W-1:0] ThrOn,
    input  logic [W-1:0] ThrOff,
    output logic         Detect
);

    localparam int unsigned HW        = clog2(HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    logic [HW-1:0] hold_q;
    logic          det_q;
    logic          qual;

    // Only the threshold that can move the flag out of its current state is evaluated.
    always_comb begin
        qual = det_q ? (AvgOut < ThrOff) : (AvgOut >= ThrOn);
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            hold_q <= '0;
            det_q  <= 1'b0;
        end else if (AvgVld) begin
            if (!qual) begin
                hold_q <= '0;
            end else if (hold_q == HOLD_LAST) begin
                hold_q <= '0;
                det_q  <= ~det_q;
            end else begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign Detect = det_q;

endmodule

// File: rtl/sort_sum_detect.sv
// sort_sum_detect: frames the sorter's DataEn stream, reports the rounded top-16 average
// and max per frame, drives Detect. Optional PeakOut under SORT_DET_PEAK_EN.
module sort_sum_detect
    import sort_pkg::*;
#(
    parameter int unsigned W         = 12,
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned LAT       = 2,
    parameter int unsigned HOLD      = 2
) (
    input  logic         clk,
    input  logic         rst_x,
    input  logic         DataEn,
    input  logic         FrameStart,
    input  logic [W-1:0] DataMax,
    input  logic [W+3:0] DataSumOut,
    input  logic [W-1:0] ThrOn,
    input  logic [W-1:0] ThrOff,
    output logic [W-1:0] AvgOut,
    output logic [W-1:0] MaxOut,
    output logic         AvgVld,
    output logic         Detect
`ifdef SORT_DET_PEAK_EN
    ,
    output logic [W-1:0] PeakOut
`endif
);

    localparam int unsigned   CW       = clog2(FRAME_LEN);
    localparam int unsigned   AW       = W + 5;
    localparam logic [CW-1:0] SMP_LAST = CW'(FRAME_LEN - 1);
    localparam logic [2:0]    LAT_LAST = 3'((LAT == 0) ? 0 : LAT - 1);

    frame_state_e  state_q;
    logic [CW-1:0] smp_cnt_q;
    logic [2:0]    lat_cnt_q;
    logic          rep_q;
    logic          avg_vld_q;
    logic [W-1:0]  avg_q;
    logic [W-1:0]  max_q;

    logic          smp_last;
    logic [W+4:0]  rnd_sum;
    logic [W:0]    avg_full;
    logic [W-1:0]  avg_d;

    assign smp_last = DataEn && (smp_cnt_q == SMP_LAST);

    always_comb begin
        rnd_sum  = {1'b0, DataSumOut} + AW'(RND);
        avg_full = (W + 1)'(rnd_sum >> SUM_SHIFT);
        avg_d    = avg_full[W] ? '1 : avg_full[W-1:0];
    end

    // FrameStart also drops a report already latched but not yet flagged, so an
    // aborted frame can never raise AvgVld.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q   <= ST_COUNT;
            smp_cnt_q <= '0;
            lat_cnt_q <= '0;
            rep_q     <= 1'b0;
            avg_vld_q <= 1'b0;
            avg_q     <= '0;
            max_q     <= '0;
        end else if (FrameStart) begin
            state_q   <= ST_COUNT;
            smp_cnt_q <= DataEn ? CW'(1) : '0;
            lat_cnt_q <= '0;
            rep_q     <= 1'b0;
            avg_vld_q <= 1'b0;
        end else begin
            avg_vld_q <= rep_q;
            rep_q     <= 1'b0;
            if (DataEn) begin
                smp_cnt_q <= smp_last ? '0 : smp_cnt_q + 1'b1;
            end
            case (state_q)
                ST_COUNT: begin
                    if (smp_last) begin
                        state_q   <= (LAT == 0) ? ST_REPORT : ST_WAIT;
                        lat_cnt_q <= '0;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        state_q <= ST_REPORT;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 3'd1;
                    end
                end
                ST_REPORT: begin
                    avg_q   <= avg_d;
                    max_q   <= DataMax;
                    rep_q   <= 1'b1;
                    state_q <= ST_COUNT;
                end
                default: begin
                    state_q <= ST_COUNT;
                end
            endcase
        end
    end

    assign AvgOut = avg_q;
    assign MaxOut = max_q;
    assign AvgVld = avg_vld_q;

    sort_hyst_fsm #(
        .W    (W),
        .HOLD (HOLD)
    ) u_hyst (
        .clk    (clk),
        .rst_x  (rst_x),
        .AvgVld (avg_vld_q),
        .AvgOut (avg_q),
        .ThrOn  (ThrOn),
        .ThrOff (ThrOff),
        .Detect (Detect)
    );

`ifdef SORT_DET_PEAK_EN
    logic [W-1:0] peak_q;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            peak_q <= '0;
        end else if (FrameStart) begin
            peak_q <= '0;
        end else if (avg_vld_q && (max_q > peak_q)) begin
            peak_q <= max_q;
        end
    end

    assign PeakOut = peak_q;
`endif

endmodule

// File: tb/tb_sort_sum_detect.sv
// tb_sort_sum_detect: directed frame-level bench for sort_sum_detect with hand-computed
// averages, latencies and Detect sequences.
module tb_sort_sum_detect;

    localparam int unsigned W         = 12;
    localparam int unsigned FRAME_LEN = 64;
    localparam int unsigned LAT       = 2;
    localparam int unsigned HOLD      = 2;
    localparam int FIRST_CYC = 68;  // FrameStart/reset-release negedge to first AvgVld negedge
    localparam int NEXT_CYC  = 63;  // from the negedge after one AvgVld to the next one

    logic         clk = 1'b0;
    logic         rst_x;
    logic         DataEn;
    logic         FrameStart;
    logic [W-1:0] DataMax;
    logic [W+3:0] DataSumOut;
    logic [W-1:0] ThrOn;
    logic [W-1:0] ThrOff;
    logic [W-1:0] AvgOut;
    logic [W-1:0] MaxOut;
    logic         AvgVld;
    logic         Detect;
`ifdef SORT_DET_PEAK_EN
    logic [W-1:0] PeakOut;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    sort_sum_detect #(
        .W         (W),
        .FRAME_LEN (FRAME_LEN),
        .LAT       (LAT),
        .HOLD      (HOLD)
    ) dut (
        .clk        (clk),
        .rst_x      (rst_x),
        .DataEn     (DataEn),
        .FrameStart (FrameStart),
        .DataMax    (DataMax),
        .DataSumOut (DataSumOut),
        .ThrOn      (ThrOn),
        .ThrOff     (ThrOff),
        .AvgOut     (AvgOut),
        .MaxOut     (MaxOut),
        .AvgVld     (AvgVld),
        .Detect     (Detect)
`ifdef SORT_DET_PEAK_EN
        ,
        .PeakOut    (PeakOut)
`endif
    );

    // Advances negedge by negedge until AvgVld is seen (bounded); FrameStart is a one-cycle pulse.
    task automatic wait_vld(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            FrameStart = 1'b0;
            cyc++;
        end while (AvgVld !== 1'b1 && cyc < 300);
    endtask

    task automatic test_reset();
        bit quiet;
        rst_x = 1'b0; DataEn = 1'b0; FrameStart = 1'b0;
        DataMax = '0; DataSumOut = '0; ThrOn = 12'd200; ThrOff = 12'd150;
        repeat (3) @(negedge clk);
        vec_cnt++; if (AvgOut !== '0) begin err_cnt++; $display("FAIL reset_avg: got %0d want 0", AvgOut); end
        vec_cnt++; if (MaxOut !== '0) begin err_cnt++; $display("FAIL reset_max: got %0d want 0", MaxOut); end
        vec_cnt++; if (AvgVld !== 1'b0) begin err_cnt++; $display("FAIL reset_vld: got %b want 0", AvgVld); end
        vec_cnt++; if (Detect !== 1'b0) begin err_cnt++; $display("FAIL reset_det: got %b want 0", Detect); end
        rst_x = 1'b1;
        quiet = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (AvgVld !== 1'b0) quiet = 1'b0;
        end
        vec_cnt++; if (quiet !== 1'b1) begin err_cnt++; $display("FAIL idle_no_vld: got AvgVld pulse want none"); end
    endtask

    task automatic test_frame();
        int cyc;
        DataSumOut = 16'd1600; DataMax = 12'd300;
        FrameStart = 1'b1; DataEn = 1'b1;
        wait_vld(cyc);
        vec_cnt++; if (cyc !== FIRST_CYC) begin err_cnt++; $display("FAIL frame_latency: got %0d want %0d", cyc, FIRST_CYC); end
        vec_cnt++; if (AvgOut !== 12'd100) begin err_cnt++; $display("FAIL frame_avg: got %0d want 100", AvgOut); end
        vec_cnt++; if (MaxOut !== 12'd300) begin err_cnt++; $display("FAIL frame_max: got %0d want 300", MaxOut); end
        @(negedge clk);
        vec_cnt++; if (AvgVld !== 1'b0) begin err_cnt++; $display("FAIL vld_pulse_width: got %b want 0", AvgVld); end
        DataMax = 12'd301;
        wait_vld(cyc);
        vec_cnt++; if (cyc !== NEXT_CYC) begin err_cnt++; $display("FAIL frame_period: got %0d want %0d", cyc, NEXT_CYC); end
        vec_cnt++; if (MaxOut !== 12'd301) begin err_cnt++; $display("FAIL frame2_max: got %0d want 301", MaxOut); end
        @(negedge clk);
    endtask

    task automatic test_round_sat();
        int cyc;
        logic [W+3:0] sum_l [4] = '{16'hFFFF, 16'd24, 16'd1607, 16'd1608};
        logic [W-1:0] exp_l [4] = '{12'd4095, 12'd2, 12'd100, 12'd101};
        logic [W-1:0] max_l [4] = '{12'd4095, 12'd1, 12'd2, 12'd3};
        for (int i = 0; i < 4; i++) begin
            DataSumOut = sum_l[i]; DataMax = max_l[i];
            wait_vld(cyc);
            vec_cnt++; if (cyc !== NEXT_CYC) begin err_cnt++; $display("FAIL round_period[%0d]: got %0d want %0d", i, cyc, NEXT_CYC); end
            vec_cnt++; if (AvgOut !== exp_l[i]) begin err_cnt++; $display("FAIL round_avg[%0d]: got %0d want %0d", i, AvgOut, exp_l[i]); end
            vec_cnt++; if (MaxOut !== max_l[i]) begin err_cnt++; $display("FAIL round_max[%0d]: got %0d want %0d", i, MaxOut, max_l[i]); end
            @(negedge clk);
        end
        vec_cnt++; if (Detect !== 1'b0) begin err_cnt++; $display("FAIL round_det: got %b want 0", Detect); end
    endtask

    task automatic test_gapped();
        int first;
        DataSumOut = 16'd1616; DataMax = 12'd9;
        FrameStart = 1'b1; DataEn = 1'b1;
        first = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            FrameStart = 1'b0;
            if (AvgVld === 1'b1) first = c;
            DataEn = (c % 2 == 0);
            if (first != 0) break;
        end
        vec_cnt++; if (first !== 131) begin err_cnt++; $display("FAIL gapped_latency: got %0d want 131", first); end
        vec_cnt++; if (AvgOut !== 12'd101) begin err_cnt++; $display("FAIL gapped_avg: got %0d want 101", AvgOut); end
        DataEn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_hysteresis();
        int cyc;
        int exp_cyc;
        logic [W-1:0] avg_l [5] = '{12'd210, 12'd220, 12'd160, 12'd140, 12'd140};
        logic         det_l [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ThrOn = 12'd200; ThrOff = 12'd150;
        for (int i = 0; i < 5; i++) begin
            DataSumOut = {avg_l[i], 4'b0000}; DataMax = avg_l[i];
            if (i == 0) FrameStart = 1'b1;
            exp_cyc = (i == 0) ? FIRST_CYC : NEXT_CYC;
            wait_vld(cyc);
            vec_cnt++; if (cyc !== exp_cyc) begin err_cnt++; $display("FAIL hyst_period[%0d]: got %0d want %0d", i, cyc, exp_cyc); end
            vec_cnt++; if (AvgOut !== avg_l[i]) begin err_cnt++; $display("FAIL hyst_avg[%0d]: got %0d want %0d", i, AvgOut, avg_l[i]); end
            @(negedge clk);
            vec_cnt++; if (Detect !== det_l[i]) begin err_cnt++; $display("FAIL hyst_det[%0d]: got %b want %b", i, Detect, det_l[i]); end
        end
    endtask

    task automatic test_hold_clear();
        int cyc;
        logic [W-1:0] avg_l [4] = '{12'd210, 12'd100, 12'd210, 12'd210};
        logic         det_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            DataSumOut = {avg_l[i], 4'b0000}; DataMax = avg_l[i];
            wait_vld(cyc);
            vec_cnt++; if (cyc !== NEXT_CYC) begin err_cnt++; $display("FAIL hold_period[%0d]: got %0d want %0d", i, cyc, NEXT_CYC); end
            @(negedge clk);
            vec_cnt++; if (Detect !== det_l[i]) begin err_cnt++; $display("FAIL hold_det[%0d]: got %b want %b", i, Detect, det_l[i]); end
        end
    endtask

    task automatic test_framestart_abort();
        int cyc;
        bit no_vld;
        vec_cnt++; if (Detect !== 1'b1) begin err_cnt++; $display("FAIL abort_det_pre: got %b want 1", Detect); end
        DataSumOut = 16'd2240; DataMax = 12'd140;
        no_vld = 1'b1;
        repeat (59) begin
            @(negedge clk);
            if (AvgVld !== 1'b0) no_vld = 1'b0;
        end
        // Last sample of the frame has just been accepted: the block is waiting out LAT.
        FrameStart = 1'b1;
        DataSumOut = 16'd3520; DataMax = 12'd220;
        repeat (5) begin
            @(negedge clk);
            FrameStart = 1'b0;
            if (AvgVld !== 1'b0) no_vld = 1'b0;
        end
        vec_cnt++; if (no_vld !== 1'b1) begin err_cnt++; $display("FAIL abort_no_vld: got AvgVld pulse want none"); end
        vec_cnt++; if (AvgOut !== 12'd210) begin err_cnt++; $display("FAIL abort_avg_held: got %0d want 210", AvgOut); end
        vec_cnt++; if (Detect !== 1'b1) begin err_cnt++; $display("FAIL abort_det_held: got %b want 1", Detect); end
        wait_vld(cyc);
        vec_cnt++; if (cyc !== FIRST_CYC - 5) begin err_cnt++; $display("FAIL abort_next_vld: got %0d want %0d", cyc, FIRST_CYC - 5); end
        vec_cnt++; if (AvgOut !== 12'd220) begin err_cnt++; $display("FAIL abort_next_avg: got %0d want 220", AvgOut); end
        @(negedge clk);
        vec_cnt++; if (Detect !== 1'b1) begin err_cnt++; $display("FAIL abort_det_post: got %b want 1", Detect); end
    endtask

    task automatic test_async_reset();
        int cyc;
        repeat (20) @(negedge clk);
        #2 rst_x = 1'b0;
        #1;
        vec_cnt++; if (AvgOut !== '0) begin err_cnt++; $display("FAIL arst_avg: got %0d want 0", AvgOut); end
        vec_cnt++; if (MaxOut !== '0) begin err_cnt++; $display("FAIL arst_max: got %0d want 0", MaxOut); end
        vec_cnt++; if (AvgVld !== 1'b0) begin err_cnt++; $display("FAIL arst_vld: got %b want 0", AvgVld); end
        vec_cnt++; if (Detect !== 1'b0) begin err_cnt++; $display("FAIL arst_det: got %b want 0", Detect); end
        repeat (2) @(negedge clk);
        DataSumOut = 16'd1600; DataMax = 12'd55; DataEn = 1'b1;
        rst_x = 1'b1;
        wait_vld(cyc);
        vec_cnt++; if (cyc !== FIRST_CYC) begin err_cnt++; $display("FAIL arst_first_vld: got %0d want %0d", cyc, FIRST_CYC); end
        vec_cnt++; if (AvgOut !== 12'd100) begin err_cnt++; $display("FAIL arst_avg_after: got %0d want 100", AvgOut); end
        vec_cnt++; if (MaxOut !== 12'd55) begin err_cnt++; $display("FAIL arst_max_after: got %0d want 55", MaxOut); end
        @(negedge clk);
        vec_cnt++; if (Detect !== 1'b0) begin err_cnt++; $display("FAIL arst_det_after: got %b want 0", Detect); end
    endtask

`ifdef SORT_DET_PEAK_EN
    task automatic test_peak();
        int cyc;
        vec_cnt++; if (PeakOut !== 12'd55) begin err_cnt++; $display("FAIL peak_first: got %0d want 55", PeakOut); end
        DataMax = 12'd40;
        wait_vld(cyc);
        @(negedge clk);
        vec_cnt++; if (PeakOut !== 12'd55) begin err_cnt++; $display("FAIL peak_hold: got %0d want 55", PeakOut); end
        DataMax = 12'd90;
        wait_vld(cyc);
        @(negedge clk);
        vec_cnt++; if (PeakOut !== 12'd90) begin err_cnt++; $display("FAIL peak_rise: got %0d want 90", PeakOut); end
        FrameStart = 1'b1;
        @(negedge clk);
        FrameStart = 1'b0;
        vec_cnt++; if (PeakOut !== '0) begin err_cnt++; $display("FAIL peak_clear: got %0d want 0", PeakOut); end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_round_sat();
        test_gapped();
        test_hysteresis();
        test_hold_clear();
        test_framestart_abort();
        test_async_reset();
`ifdef SORT_DET_PEAK_EN
        test_peak();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
